// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, LSB first, idle-high line.
//
// Parameters
//   BAUD       clk cycles per bit (even, >= 16); default 5208 = 50 MHz / 9600
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   rx_in      asynchronous serial input
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle pulse when rx_data is updated
//   frame_err  one-cycle pulse when the stop bit samples low
//   busy       high whenever a frame is in progress (state != IDLE)
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every bit sample is the 2-of-3 majority
//                        of s2 at cnt = target-2, target-1 and target. Sample
//                        timing is unchanged; only the sampled value differs.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BAUD);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          s1_q, s2_q, s3_q;

  logic [CW-1:0] target;
  logic          at_target;
  logic          sample;

  // Synchronizer (s1, s2) plus history flop (s3) for falling-edge detection.
  // Reset to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= rx_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Start bit is checked at mid-bit; data/stop bits a full bit later, so every
  // subsequent sample also lands near the middle of its bit.
  assign target    = (state_q == START) ? HALF_M1 : FULL_M1;
  assign at_target = (cnt_q == target);

`ifdef UART_RX_MAJORITY_EN
  logic m0_q, m0_d, m1_q, m1_d;

  always_comb begin
    m0_d = m0_q;
    m1_d = m1_q;
    if (cnt_q == target - CW'(2)) m0_d = s2_q;
    if (cnt_q == target - CW'(1)) m1_d = s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_q <= 1'b1;
      m1_q <= 1'b1;
    end else begin
      m0_q <= m0_d;
      m1_q <= m1_d;
    end
  end

  assign sample = (m0_q & m1_q) | (m0_q & s2_q) | (m1_q & s2_q);
`else
  assign sample = s2_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // Edge-triggered: a line stuck low never starts a frame.
        if (s3_q && !s2_q) state_d = START;
      end
      START: begin
        if (at_target) begin
          cnt_d = '0;
          if (sample) begin
            state_d = IDLE;          // glitch, not a real start bit
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (at_target) begin
          cnt_d       = '0;
          sh_d[idx_q] = sample;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE mid-stop-bit leaves half a bit to catch the
        // next start edge of a back-to-back frame.
        if (at_target) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sample) begin
            rx_data_d  = sh_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- scoreboard bench for uart_rx at BAUD=16.
// Stimulus pushes the expected pulse (kind, byte, cycle) when a frame starts;
// a negedge monitor pops and compares whenever rx_valid or frame_err fires.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BAUD = 16;
  localparam int LAT  = 3 + BAUD / 2 + 9 * BAUD;  // 155 edges to the pulse

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  uart_rx #(.BAUD(BAUD)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] data;
    longint     at;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err)) begin
      chk("valid_and_err_exclusive", {rx_valid, frame_err} == 2'b11, 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {rx_valid, frame_err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind_err", frame_err, e.err);
        chk("pulse_kind_valid", rx_valid, !e.err);
        chk("rx_data", rx_data, e.data);
        chk("pulse_cycle", cyc, e.at);
        chk("busy_at_pulse", busy, 0);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 rx_in = 1'b1;
    end
  endtask

  // One 10-bit frame, BAUD cycles per bit. glitch_c inverts the line for one
  // cycle; abort_c asserts reset at that cycle and abandons the frame.
  task automatic send(input logic [7:0] d, input logic stop,
                      input int glitch_c, input int abort_c);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int c = 0; c < 10 * BAUD; c++) begin
      @(posedge clk);
      #1;
      if (c == abort_c) begin
        rst = 1'b1;
        rx_in = 1'b1;
        #1;
        chk("abort_rx_valid", rx_valid, 0);
        chk("abort_frame_err", frame_err, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rx_data", rx_data, 0);
        last_good = 8'h00;
        return;
      end
      if (c == 0 && abort_c < 0) begin
        exp_t e;
        e.err  = !stop;
        e.data = stop ? d : last_good;
        e.at   = cyc + LAT;
        if (stop) last_good = d;
        sb.push_back(e);
      end
      rx_in = (c == glitch_c) ? ~bits[c / BAUD] : bits[c / BAUD];
    end
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] exp_0f;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    idle(20);

    // Good frame
    send(8'h61, 1'b1, -1, -1);
    idle(20);

    // Bad stop bit: frame_err, data held at 0x61
    send(8'h55, 1'b0, -1, -1);
    idle(20);

    // Back-to-back, no idle gap: pulses 160 cycles apart
    send(8'h00, 1'b1, -1, -1);
    send(8'hFF, 1'b1, -1, -1);
    idle(20);

    // Short low pulse: START sees high at mid-bit and gives up
    busy_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1;
      busy_cnt += int'(busy);
      rx_in = (c < 4) ? 1'b0 : 1'b1;
    end
    chk("glitch_busy_cycles", busy_cnt, 8);
    idle(10);

    // Reset during data bit 4 of 0x3C, then a clean 0xA5
    send(8'h3C, 1'b1, -1, 5 * BAUD + 4);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(20);
    send(8'hA5, 1'b1, -1, -1);
    idle(20);

    // One-cycle inversion exactly at the data-bit-2 sample point
`ifdef UART_RX_MAJORITY_EN
    exp_0f = 8'h0F;
`else
    exp_0f = 8'h0B;
`endif
    begin
      exp_t e;
      for (int c = 0; c < 10 * BAUD; c++) begin
        @(posedge clk);
        #1;
        if (c == 0) begin
          e.err  = 1'b0;
          e.data = exp_0f;
          e.at   = cyc + LAT;
          sb.push_back(e);
        end
        rx_in = ({1'b1, 8'h0F, 1'b0} >> (c / BAUD)) & 1'b1;
        if (c == 3 * BAUD + 8) rx_in = ~rx_in;
      end
    end
    idle(40);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
